// File: rtl/alu_defines.sv
// alu_defines: op-code constants shared between alu_controller and alu_core.
// Contents: AWIDTH (aluop width), the ten ALU op codes, and a helper that
// tells whether an op code is one of the three shift operations.
// Codes 10..15 are not named here; alu_core executes them as ADD.
package alu_defines;

  localparam int AWIDTH = 4;

  localparam logic [AWIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [AWIDTH-1:0] OP_SUB  = 4'd1;
  localparam logic [AWIDTH-1:0] OP_XOR  = 4'd2;
  localparam logic [AWIDTH-1:0] OP_OR   = 4'd3;
  localparam logic [AWIDTH-1:0] OP_AND  = 4'd4;
  localparam logic [AWIDTH-1:0] OP_SLL  = 4'd5;
  localparam logic [AWIDTH-1:0] OP_SRL  = 4'd6;
  localparam logic [AWIDTH-1:0] OP_SRA  = 4'd7;
  localparam logic [AWIDTH-1:0] OP_SLT  = 4'd8;
  localparam logic [AWIDTH-1:0] OP_SLTU = 4'd9;

  // True for the ops that go through the shifter
  function automatic logic is_shift(input logic [AWIDTH-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: iterative one-bit-per-cycle shifter used by alu_core.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       load operand/op/count and begin shifting (only pulsed by the
//               parent while idle and with a non-zero amount)
//   op          shift op code (SLL/SRL/SRA)
//   a           operand to shift
//   amt         shift amount, must be non-zero when start is pulsed
//   busy        a shift is in progress
//   done        high during the cycle whose rising edge performs the final
//               shift; shifted then holds the finished value
//   shifted     accumulator after one more shift step
// Not compiled when ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
  import alu_defines::*;
#(
  parameter int WIDTH  = 32,
  parameter int SWIDTH = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] op,
  input  logic [WIDTH-1:0]  a,
  input  logic [SWIDTH-1:0] amt,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  shifted
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  acc;
  logic [SWIDTH-1:0] cnt;
  logic [AWIDTH-1:0] op_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state: leave IDLE on a load, return once the last bit is shifted
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (cnt == SWIDTH'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and remaining count
  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_SHIFT) && (cnt == SWIDTH'(1));
  end

  // Accumulator, counter and op capture; operands are frozen at load time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_SLL;
    end else if (state == S_IDLE) begin
      if (start) begin
        acc  <= a;
        cnt  <= amt;
        op_q <= op;
      end
    end else begin
      acc <= shifted;
      cnt <= cnt - SWIDTH'(1);
    end
  end

  // One-bit step; SRA re-copies the top bit, which keeps the original sign
  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc[WIDTH-1:1]};
      default: shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: registered execute-stage ALU for piRISC.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   start     request, accepted on a rising edge while busy is low
//   aluop     op code from alu_controller (10..15 execute as ADD)
//   a, b      operands; shifts use b[SWIDTH-1:0] as the amount
//   busy      iterative shift in progress, new requests ignored
//   done      one-cycle pulse when result/zero are updated
//   result    registered result, held until the next done
//   zero      registered (result == 0)
// Macro ALU_BARREL_SHIFT_EN: when defined, shifts use a single-cycle barrel
// shifter, every op has latency 1 and busy is tied low; otherwise shifts go
// through the iterative alu_shift_unit (latency n+1 for amount n>0).
module alu_core
  import alu_defines::*;
#(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = alu_defines::AWIDTH,
  parameter int SWIDTH = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] aluop,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              zero
);

  logic [SWIDTH-1:0] amt;
  logic              accept;
  logic              fast;
  logic [WIDTH-1:0]  alu_val;
  logic              sh_done;
  logic [WIDTH-1:0]  sh_val;

  assign amt    = b[SWIDTH-1:0];
  assign accept = start && !busy;

`ifdef ALU_BARREL_SHIFT_EN
  assign busy    = 1'b0;
  assign sh_done = 1'b0;
  assign sh_val  = '0;
  assign fast    = accept;
`else
  logic sh_start;

  // Only non-zero shifts need the iterative unit; a zero shift is just a copy
  assign sh_start = accept && is_shift(aluop) && (amt != '0);
  assign fast     = accept && !sh_start;

  alu_shift_unit #(
    .WIDTH (WIDTH),
    .SWIDTH(SWIDTH)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (sh_start),
    .op     (aluop),
    .a      (a),
    .amt    (amt),
    .busy   (busy),
    .done   (sh_done),
    .shifted(sh_val)
  );
`endif

  // Single-cycle datapath; unnamed op codes fall through to ADD
  always_comb begin
    case (aluop)
      OP_SUB:  alu_val = a - b;
      OP_XOR:  alu_val = a ^ b;
      OP_OR:   alu_val = a | b;
      OP_AND:  alu_val = a & b;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_val = a << amt;
      OP_SRL:  alu_val = a >> amt;
      OP_SRA:  alu_val = $signed(a) >>> amt;
`else
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_val = a;
`endif
      default: alu_val = a + b;
    endcase
  end

  // Result register; fast ops and shift completion never coincide because
  // fast needs busy low and shift completion happens while busy is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fast) begin
        result <= alu_val;
        zero   <= (alu_val == '0);
        done   <= 1'b1;
      end else if (sh_done) begin
        result <= sh_val;
        zero   <= (sh_val == '0);
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed self-checking bench for alu_core.
// Build with ALU_BARREL_SHIFT_EN defined to check the barrel-shifter timing.
module tb_alu_core;
  import alu_defines::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  aluop = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int total = 0;
  int bad   = 0;

  alu_core dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .aluop (aluop),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single-cycle op: start in cycle 0, check done/result/zero in cycle 1
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; aluop = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".result"}, result, exp);
    checkOutput({tag, ".zero"}, 32'(zero), 32'(exp == 32'd0));
  endtask

  // Shift op with latency/busy checking; optionally disturbs inputs while busy
  task automatic runShift(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int n, input logic [31:0] exp,
                          input bit disturb);
    int cyc;
    int busyCnt;
    int expLat;
    int expBusy;
`ifdef ALU_BARREL_SHIFT_EN
    expLat  = 1;
    expBusy = 0;
`else
    expLat  = n + 1;
    expBusy = n;
`endif
    @(negedge clk);
    start = 1'b1; aluop = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busyCnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busyCnt++;
      if (disturb && cyc == 2) begin
        start = 1'b1; aluop = OP_ADD; a = 32'h7; b = 32'h9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput({tag, ".latency"}, 32'(cyc), 32'(expLat));
    checkOutput({tag, ".busycycles"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, ".result"}, result, exp);
    checkOutput({tag, ".zero"}, 32'(zero), 32'(exp == 32'd0));
    @(negedge clk);
    checkOutput({tag, ".no_extra_done"}, 32'(done), 32'd0);
    checkOutput({tag, ".held"}, result, exp);
  endtask

  initial begin
    int doneSeen;
    $display("[TB] alu_core directed test");
    #12;
    checkOutput("rst.result", result, 32'd0);
    checkOutput("rst.zero", 32'(zero), 32'd1);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    applyStimulus("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    applyStimulus("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    applyStimulus("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    applyStimulus("op12", 4'd12, 32'd3, 32'd4, 32'd7);
    applyStimulus("xor", OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F);

    runShift("sra4", OP_SRA, 32'h8000_0000, 32'h0000_0024, 4, 32'hF800_0000, 1'b0);
    runShift("sll31", OP_SLL, 32'h0000_0001, 32'd31, 31, 32'h8000_0000, 1'b1);
    runShift("srl3", OP_SRL, 32'hF000_0000, 32'd3, 3, 32'h1E00_0000, 1'b0);
    runShift("sll0", OP_SLL, 32'h0000_0005, 32'h0000_0020, 0, 32'h0000_0005, 1'b0);

    // Back-to-back single-cycle ops
    @(negedge clk);
    start = 1'b1; aluop = OP_AND; a = 32'h0000_F0F0; b = 32'h0000_FF00;
    @(negedge clk);
    checkOutput("b2b.and.done", 32'(done), 32'd1);
    checkOutput("b2b.and.result", result, 32'h0000_F000);
    aluop = OP_OR; a = 32'h0000_0F0F; b = 32'h0000_F000;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b.or.done", 32'(done), 32'd1);
    checkOutput("b2b.or.result", result, 32'h0000_FF0F);
    @(negedge clk);
    checkOutput("b2b.idle.done", 32'(done), 32'd0);

    // Reset in cycle 3 of a 10-bit shift
    @(negedge clk);
    start = 1'b1; aluop = OP_SRL; a = 32'hFFFF_FFFF; b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.result", result, 32'd0);
    checkOutput("abort.zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort.no_done", 32'(doneSeen), 32'd0);
    applyStimulus("after_abort", OP_ADD, 32'd3, 32'd4, 32'd7);
    runShift("after_abort_sra", OP_SRA, 32'h4000_0000, 32'd2, 2, 32'h1000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so a stuck design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_core.md
# alu_core

Registered execute-stage ALU for piRISC, directly downstream of `alu_controller`: consumes its 4-bit `aluop` with two operands and returns a registered result with a one-cycle `done` pulse. Add/sub/logic/compare complete in one cycle; shifts use an iterative one-bit-per-cycle shifter (or a barrel shifter when configured), so the block exposes a start/busy/done handshake to the pipeline control.

## Interface
- `WIDTH`, 32, operand/result width; power of two, ≥8
- `AWIDTH`, 4, aluop width; matches `alu_controller`
- `SWIDTH`, log2(WIDTH) = 5, shift-amount width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled on a rising edge only while `busy`=0
- `aluop`  in  AWIDTH  operation code from `alu_controller`
- `a`  in  WIDTH  operand A (rs1)
- `b`  in  WIDTH  operand B (rs2/imm); shifts use `b[SWIDTH-1:0]`
- `busy`  out  1  iterative shift in progress; new `start` ignored
- `done`  out  1  one-cycle pulse: `result`/`zero` updated this cycle
- `result`  out  WIDTH  registered result, held until next `done`
- `zero`  out  1  registered `result == 0`

## Operation
- Op codes, from the shared `alu_defines`: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9; codes 10–15 execute as ADD.
- ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
- SLT: signed compare a<b; SLTU: unsigned; result = {WIDTH-1 zeros, bit}.
- SRA fills with `a[WIDTH-1]` of the operand captured at start; SRL/SLL fill with 0.
- States: IDLE, SHIFT.
  - IDLE, `start`=1, non-shift op or shift amount 0: compute, write `result`/`zero`, pulse `done`; stay IDLE.
  - IDLE, `start`=1, shift op, amount n>0: capture `a`, op, count=n; go SHIFT.
  - SHIFT: each edge shifts accumulator one bit, count−1; the edge performing the final shift writes `result`/`zero`, pulses `done`, returns to IDLE.
- Operands and `aluop` are captured at the accepting edge; changes afterwards do not affect the operation in flight.
- `start` while `busy`=1: ignored, not queued.
- Reset (any state, incl. mid-shift): abort, state IDLE, `result`=0, `zero`=1, `busy`=0, `done`=0.

## Timing
- `start` high in cycle 0 → non-shift op (or shift by 0): `done`=1 in cycle 1; latency 1.
- Shift by n>0: `busy`=1 in cycles 1..n, `done`=1 in cycle n+1; latency n+1, maximum WIDTH.
- `busy` is low in the `done` cycle; a `start` in that cycle is accepted (back-to-back, one op per cycle for single-cycle ops).
- `done` is never high in two consecutive cycles except for back-to-back accepted requests.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined: shifts are computed by a single-cycle barrel shifter; every op has latency 1; SHIFT state and counter are not compiled; `busy` is tied to 0.
- Not defined: iterative shifter as described above; smaller area, variable latency.

## Structure
- `alu_defines` (shared with `alu_controller`): the ten op-code constants and `AWIDTH`. The IDLE/SHIFT state encodings are local to `alu_core`.
- One sub-module: `alu_shift_unit`, holding the accumulator, counter and fill logic, with start/busy/done ports. It is replaced by the barrel shifter under `ALU_BARREL_SHIFT_EN`.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, start in cycle 0 → cycle 1: `done`=1, `result`=0, `zero`=1; SUB 5−7 → 0xFFFFFFFE.
- SLT a=0xFFFFFFFF, b=1 → 1; SLTU same operands → 0; aluop=12 with 3,4 → 7 (ADD default).
- SRA a=0x80000000, b=0x00000024 (n=4) → `busy` in cycles 1–4, `done` in cycle 5, `result`=0xF8000000; with the macro, `done` in cycle 1.
- SLL a=1, n=31 → `done` in cycle 32, `result`=0x80000000; start pulses and operand changes during `busy` are ignored, and the result is unchanged.
- Back-to-back: AND then OR, start in cycles 0 and 1 → `done` in cycles 1 and 2 with the correct results.
- Assert `rst` in cycle 3 of an n=10 shift → `busy`=0, `result`=0, `zero`=1 immediately; no `done` pulse follows; the next start behaves normally.
